// File: rtl/dragster_spi_responder_pkg.sv
// dragster_spi_responder_pkg: frame geometry, FSM encoding and default register map
package dragster_spi_responder_pkg;
    localparam int DRAGSTER_FRAME_BITS = 16;
    localparam int DRAGSTER_ADDR_BITS  = 8;
    localparam int DRAGSTER_RW_BIT     = 7;
    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_DONE} state_t;
    localparam logic [6:0] REG_CTRL     = 7'h00;
    localparam logic [6:0] REG_GAIN     = 7'h01;
    localparam logic [6:0] REG_EXPOSURE = 7'h02;
    localparam logic [6:0] REG_MODE     = 7'h03;
endpackage

// File: rtl/dragster_spi_responder_if.sv
// dragster_spi_responder_if: SPI mode-0 wire bundle between configurator and responder
interface dragster_spi_responder_if;
    logic sclk;
    logic ss_n;
    logic mosi;
    logic miso;
    modport master(output sclk, output ss_n, output mosi, input miso);
    modport slave(input sclk, input ss_n, input mosi, output miso);
endinterface

// File: rtl/dragster_spi_responder_spi_input_sync.sv
// spi_input_sync: 2-FF synchronisers for sclk/ss_n/mosi plus edge pulses in the clk domain.
// sclk_fall port exists only when DRAGSTER_SPI_READBACK_EN is defined.
module spi_input_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic sclk,
    input  logic ss_n,
    input  logic mosi,
    output logic sclk_rise,
`ifdef DRAGSTER_SPI_READBACK_EN
    output logic sclk_fall,
`endif
    output logic ss_fall,
    output logic ss_rise,
    output logic mosi_s
);
    logic [2:0] sclk_q, ss_q;
    logic [1:0] mosi_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_q <= 3'b000;
            ss_q   <= 3'b111;
            mosi_q <= 2'b00;
        end else begin
            sclk_q <= {sclk_q[1:0], sclk};
            ss_q   <= {ss_q[1:0], ss_n};
            mosi_q <= {mosi_q[0], mosi};
        end
    end
    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
`ifdef DRAGSTER_SPI_READBACK_EN
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
`endif
    assign ss_fall = ~ss_q[1] & ss_q[2];
    assign ss_rise = ss_q[1] & ~ss_q[2];
    assign mosi_s  = mosi_q[1];
endmodule

// File: rtl/dragster_spi_responder.sv
// dragster_spi_responder: SPI mode-0 slave decoding 16-bit register-write frames into a register file.
// DRAGSTER_SPI_READBACK_EN adds read frames returning regs[addr] on miso.
module dragster_spi_responder
    import dragster_spi_responder_pkg::*;
#(
    parameter int NUM_REGS   = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    dragster_spi_responder_if.slave   spi,
    input  logic [ADDR_WIDTH-1:0]     rd_addr,
    output logic [7:0]                rd_data,
    output logic                      wr_strobe,
    output logic [ADDR_WIDTH-1:0]     wr_addr,
    output logic [7:0]                wr_data,
    output logic                      frame_error
);
    localparam logic [3:0] LAST_ADDR_BIT = 4'(DRAGSTER_ADDR_BITS - 1);
    localparam logic [3:0] LAST_BIT      = 4'(DRAGSTER_FRAME_BITS - 1);
`ifdef DRAGSTER_SPI_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif
    state_t state, state_nx;
    logic [3:0] bit_cnt;
    logic [6:0] shift;
    logic [7:0] hdr, byte_in;
    logic [7:0] regs [NUM_REGS];
    logic sclk_rise, ss_fall, ss_rise, mosi_s;
    logic in_frame, hdr_done, hdr_valid, commit, err;
`ifdef DRAGSTER_SPI_READBACK_EN
    logic sclk_fall;
`endif
    spi_input_sync u_sync (
        .clk       (clk),
        .reset_n   (reset_n),
        .sclk      (spi.sclk),
        .ss_n      (spi.ss_n),
        .mosi      (spi.mosi),
        .sclk_rise (sclk_rise),
`ifdef DRAGSTER_SPI_READBACK_EN
        .sclk_fall (sclk_fall),
`endif
        .ss_fall   (ss_fall),
        .ss_rise   (ss_rise),
        .mosi_s    (mosi_s)
    );
    assign byte_in   = {shift, mosi_s};
    assign in_frame  = (state == ST_ADDR) || (state == ST_DATA);
    assign hdr_done  = sclk_rise && state == ST_ADDR && bit_cnt == LAST_ADDR_BIT;
    assign hdr_valid = int'(hdr[6:0]) < NUM_REGS;
    assign rd_data   = int'(rd_addr) < NUM_REGS ? regs[rd_addr] : 8'h00;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        commit   = 1'b0;
        err      = 1'b0;
        if (ss_fall) begin
            state_nx = ST_ADDR;
        end else if (ss_rise) begin
            state_nx = ST_IDLE;
            err      = in_frame;
        end else if (hdr_done) begin
            state_nx = ST_DATA;
        end else if (sclk_rise && state == ST_DATA && bit_cnt == LAST_BIT) begin
            state_nx = ST_DONE;
            commit   = !hdr[DRAGSTER_RW_BIT] && hdr_valid;
            err      = !hdr_valid && (!hdr[DRAGSTER_RW_BIT] || READBACK);
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt     <= '0;
            shift       <= '0;
            hdr         <= '0;
            wr_strobe   <= 1'b0;
            frame_error <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            wr_strobe   <= commit;
            frame_error <= err;
            if (ss_fall) bit_cnt <= '0;
            else if (sclk_rise && in_frame) begin
                shift <= byte_in[6:0];
                if (state_nx != ST_DONE) bit_cnt <= bit_cnt + 4'd1;
            end
            if (hdr_done) hdr <= byte_in;
            if (commit) begin
                regs[hdr[ADDR_WIDTH-1:0]] <= byte_in;
                wr_addr <= hdr[ADDR_WIDTH-1:0];
                wr_data <= byte_in;
            end
        end
    end
`ifdef DRAGSTER_SPI_READBACK_EN
    logic [7:0] tx;
    logic rd_act, miso_q;
    // tx is loaded at the 8th rise so its MSB can leave on the 8th fall
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx     <= '0;
            rd_act <= 1'b0;
            miso_q <= 1'b0;
        end else if (ss_fall) begin
            rd_act <= 1'b0;
            miso_q <= 1'b0;
        end else if (hdr_done) begin
            rd_act <= byte_in[DRAGSTER_RW_BIT];
            tx     <= byte_in[DRAGSTER_RW_BIT] && int'(byte_in[6:0]) < NUM_REGS ? regs[byte_in[ADDR_WIDTH-1:0]] : 8'h00;
        end else if (sclk_fall && state == ST_DATA && rd_act) begin
            {miso_q, tx} <= {tx, 1'b0};
        end
    end
    assign spi.miso = miso_q && rd_act && !spi.ss_n && state == ST_DATA;
`else
    assign spi.miso = 1'b0;
`endif
endmodule

// File: tb/tb_dragster_spi_responder.sv
// tb_dragster_spi_responder: directed write/abort/range/readback/reset vectors against dragster_spi_responder.
// Readback vector expectations follow DRAGSTER_SPI_READBACK_EN.
module tb_dragster_spi_responder;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [3:0] rd_addr = '0;
    logic [7:0] rd_data, wr_data;
    logic [3:0] wr_addr;
    logic wr_strobe, frame_error;
    int n_vec = 0;
    int n_bad = 0;
    int n_stb = 0;
    int n_err = 0;
    logic [7:0] model [16];
    logic [7:0] rx;
    dragster_spi_responder_if spi();
    dragster_spi_responder #(.NUM_REGS(16), .ADDR_WIDTH(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .spi         (spi),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .wr_strobe   (wr_strobe),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .frame_error (frame_error)
    );
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (wr_strobe) n_stb++;
        if (frame_error) n_err++;
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic spi_xfer(input logic [15:0] frame, input int nbits, output logic [7:0] rx_byte);
        rx_byte = '0;
        spi.ss_n = 1'b0;
        #80;
        for (int i = 0; i < nbits; i++) begin
            spi.mosi = frame[15-i];
            #40 spi.sclk = 1'b1;
            if (i >= 8) rx_byte = {rx_byte[6:0], spi.miso};
            #40 spi.sclk = 1'b0;
        end
        #40 spi.ss_n = 1'b1;
        #200;
    endtask
    task automatic check_regs(input string tag);
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i);
            #1 check(tag, 32'(rd_data), 32'(model[i]));
        end
    endtask
    initial begin
        int s0, e0;
        spi.sclk = 1'b0;
        spi.ss_n = 1'b1;
        spi.mosi = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        #40 reset_n = 1'b1;
        #40;
        check("rst_strobe", 32'(wr_strobe), 0);
        check("rst_wr_addr", 32'(wr_addr), 0);
        check("rst_wr_data", 32'(wr_data), 0);
        check("rst_ferr", 32'(frame_error), 0);
        check("rst_miso", 32'(spi.miso), 0);
        check_regs("rst_regs");
        // single write
        s0 = n_stb; e0 = n_err;
        spi_xfer(16'h03C0, 16, rx);
        model[3] = 8'hC0;
        check("w1_strobes", 32'(n_stb - s0), 1);
        check("w1_errs", 32'(n_err - e0), 0);
        check("w1_wr_addr", 32'(wr_addr), 32'h3);
        check("w1_wr_data", 32'(wr_data), 32'hC0);
        rd_addr = 4'd3;
        #1 check("w1_rd3", 32'(rd_data), 32'hC0);
        // back-to-back writes
        s0 = n_stb;
        spi_xfer(16'h0513, 16, rx); model[5] = 8'h13;
        spi_xfer(16'h0232, 16, rx); model[2] = 8'h32;
        spi_xfer(16'h03C0, 16, rx); model[3] = 8'hC0;
        spi_xfer(16'h091F, 16, rx); model[9] = 8'h1F;
        spi_xfer(16'h01A9, 16, rx); model[1] = 8'hA9;
        check("b2b_strobes", 32'(n_stb - s0), 5);
        check("b2b_wr_addr", 32'(wr_addr), 32'h1);
        check("b2b_wr_data", 32'(wr_data), 32'hA9);
        check_regs("b2b_regs");
        // aborted after 11 bits
        s0 = n_stb; e0 = n_err;
        spi_xfer(16'h0455, 11, rx);
        check("abort_errs", 32'(n_err - e0), 1);
        check("abort_strobes", 32'(n_stb - s0), 0);
        rd_addr = 4'd4;
        #1 check("abort_rd4", 32'(rd_data), 0);
        // out-of-range write
        s0 = n_stb; e0 = n_err;
        spi_xfer(16'h20FF, 16, rx);
        check("oor_errs", 32'(n_err - e0), 1);
        check("oor_strobes", 32'(n_stb - s0), 0);
        check("oor_wr_addr", 32'(wr_addr), 32'h1);
        check_regs("oor_regs");
        // read frame of reg 3
        s0 = n_stb; e0 = n_err;
        spi_xfer(16'h8300, 16, rx);
`ifdef DRAGSTER_SPI_READBACK_EN
        check("rd_miso_byte", 32'(rx), 32'hC0);
`else
        check("rd_miso_byte", 32'(rx), 0);
`endif
        check("rd_strobes", 32'(n_stb - s0), 0);
        check("rd_errs", 32'(n_err - e0), 0);
        check_regs("rd_regs");
        // reset in the middle of a frame
        spi.ss_n = 1'b0;
        #80;
        for (int i = 0; i < 6; i++) begin
            spi.mosi = i[0];
            #40 spi.sclk = 1'b1;
            #40 spi.sclk = 1'b0;
        end
        reset_n = 1'b0;
        rd_addr = 4'd3;
        #1;
        check("mrst_rd3", 32'(rd_data), 0);
        check("mrst_wr_addr", 32'(wr_addr), 0);
        check("mrst_wr_data", 32'(wr_data), 0);
        check("mrst_strobe", 32'(wr_strobe), 0);
        check("mrst_ferr", 32'(frame_error), 0);
        check("mrst_miso", 32'(spi.miso), 0);
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        #39 spi.ss_n = 1'b1;
        #40 reset_n = 1'b1;
        #40;
        s0 = n_stb; e0 = n_err;
        spi_xfer(16'h075A, 16, rx);
        model[7] = 8'h5A;
        check("post_strobes", 32'(n_stb - s0), 1);
        check("post_errs", 32'(n_err - e0), 0);
        check("post_wr_addr", 32'(wr_addr), 32'h7);
        check("post_wr_data", 32'(wr_data), 32'h5A);
        check_regs("post_regs");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
